// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } imem_state_e;

  function automatic int imem_aw(input int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Fixed-latency fetch response pipe: LAT stages of valid/data/fault.
// Data stages only load on a valid input so the output word holds between responses.
import imem_pkg::*;

module imem_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_vld_i,
  input  logic [DW-1:0] in_dat_i,
  input  logic          in_flt_i,
  output logic          out_vld_o,
  output logic [DW-1:0] out_dat_o,
  output logic          out_flt_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] flt_q;
  logic [DW-1:0]  dat_q [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      flt_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      if (in_vld_i) begin
        dat_q[0] <= in_dat_i;
        flt_q[0] <= in_flt_i;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          flt_q[i] <= flt_q[i-1];
        end
      end
    end
  end

  assign out_vld_o = vld_q[LAT-1];
  assign out_dat_o = dat_q[LAT-1];
  assign out_flt_o = vld_q[LAT-1] & flt_q[LAT-1];

endmodule

// File: rtl/imem_loadable.sv
// Single-port instruction memory: NOP self-fill after reset, streaming loader, pipelined fetch.
// Optional IMEM_PARITY_EN adds a stored even-parity bit, fetch_perr_o and perr_inject_i.
import imem_pkg::*;

module imem_loadable #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 1024,
  parameter int              RD_LAT   = 1,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_busy_o,
  input  logic            fetch_req_i,
  input  logic [XLEN-1:0] fetch_addr_i,
  output logic            fetch_ready_o,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic            fetch_fault_o,
`ifdef IMEM_PARITY_EN
  output logic            fetch_perr_o,
  input  logic            perr_inject_i,
`endif
  input  logic            ld_start_i,
  input  logic [XLEN-1:0] ld_base_i,
  input  logic            ld_valid_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic            ld_ready_o
);

  localparam int AW = imem_aw(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MW = XLEN + 1;
`else
  localparam int MW = XLEN;
`endif

  logic [MW-1:0]   mem [DEPTH];
  imem_state_e     state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] wr_word;
  logic [MW-1:0]   mem_wdata;
  logic [AW-1:0]   base_idx;
  logic [AW-1:0]   fetch_idx;
  logic            fetch_acc;
  logic            fetch_bad;
  logic [MW-1:0]   rd_word;
  logic [MW-1:0]   pipe_in_dat;
  logic [MW-1:0]   pipe_out_dat;
  logic            unused_ok;

  assign base_idx  = ld_base_i[AW+1:2];
  assign fetch_idx = fetch_addr_i[AW+1:2];
  assign unused_ok = ^{ld_base_i[XLEN-1:AW+2], ld_base_i[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    mem_we        = 1'b0;
    mem_waddr     = idx_q;
    wr_word       = NOP_WORD;
    init_busy_o   = 1'b0;
    ld_ready_o    = 1'b0;
    fetch_ready_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy_o = 1'b1;
        mem_we      = 1'b1;
        idx_d       = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        ld_ready_o    = 1'b1;
        // Single write/read port: a loader beat steals the cycle from fetch.
        fetch_ready_o = !ld_valid_i;
        mem_waddr     = ld_start_i ? base_idx : ptr_q;
        if (ld_start_i) ptr_d = base_idx;
        if (ld_valid_i) begin
          mem_we  = 1'b1;
          wr_word = ld_data_i;
          ptr_d   = mem_waddr + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef IMEM_PARITY_EN
  // Injection only applies to loader beats; the INIT fill always stores good parity.
  assign mem_wdata = {(^wr_word) ^ (perr_inject_i & (state_q == ST_RUN)), wr_word};
`else
  assign mem_wdata = wr_word;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign fetch_acc = fetch_req_i && fetch_ready_o;
  assign fetch_bad = (fetch_addr_i[1:0] != 2'b00) || ((fetch_addr_i >> (AW + 2)) != '0);
  assign rd_word   = mem[fetch_idx];

`ifdef IMEM_PARITY_EN
  // Top bit carries the parity-check result alongside the raw word.
  assign pipe_in_dat = fetch_bad ? {1'b0, NOP_WORD} : {^rd_word, rd_word[XLEN-1:0]};
`else
  assign pipe_in_dat = fetch_bad ? NOP_WORD : rd_word;
`endif

  imem_rd_pipe #(
    .DW  (MW),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_vld_i  (fetch_acc),
    .in_dat_i  (pipe_in_dat),
    .in_flt_i  (fetch_bad),
    .out_vld_o (fetch_valid_o),
    .out_dat_o (pipe_out_dat),
    .out_flt_o (fetch_fault_o)
  );

  assign fetch_instr_o = pipe_out_dat[XLEN-1:0];
`ifdef IMEM_PARITY_EN
  assign fetch_perr_o  = fetch_valid_o & pipe_out_dat[XLEN];
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench: two DEPTH=16 instances (RD_LAT=1 and RD_LAT=3) share one stimulus stream.
`timescale 1ns/1ps
module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, ld_start, ld_valid;
  logic [31:0] fetch_addr, ld_base, ld_data;
  logic        busy1, rdy1, vld1, flt1, ldr1, perr1;
  logic        busy3, rdy3, vld3, flt3, ldr3, perr3;
  logic [31:0] instr1, instr3;
`ifdef IMEM_PARITY_EN
  logic        perr_inject;
`endif

  always #5 clk = ~clk;

  imem_loadable #(.XLEN(32), .DEPTH(16), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .init_busy_o(busy1),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(rdy1),
    .fetch_valid_o(vld1), .fetch_instr_o(instr1), .fetch_fault_o(flt1),
`ifdef IMEM_PARITY_EN
    .fetch_perr_o(perr1), .perr_inject_i(perr_inject),
`endif
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_ready_o(ldr1)
  );

  imem_loadable #(.XLEN(32), .DEPTH(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .init_busy_o(busy3),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(rdy3),
    .fetch_valid_o(vld3), .fetch_instr_o(instr3), .fetch_fault_o(flt3),
`ifdef IMEM_PARITY_EN
    .fetch_perr_o(perr3), .perr_inject_i(perr_inject),
`endif
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_ready_o(ldr3)
  );

`ifndef IMEM_PARITY_EN
  assign perr1 = 1'b0;
  assign perr3 = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        flt;
    logic        perr;
    int          acc;
  } exp_t;

  exp_t        q1[$], q3[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          h1 = 0, h3 = 0;
  logic [31:0] last1, last3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cmp(input string tag, input int lat, input logic [31:0] instr,
                     input logic flt, input logic perr, input exp_t e);
    chk({tag, " instr"}, instr, e.instr);
    chk({tag, " fault"}, {31'd0, flt}, {31'd0, e.flt});
    chk({tag, " latency"}, cyc - e.acc, lat);
`ifdef IMEM_PARITY_EN
    chk({tag, " perr"}, {31'd0, perr}, {31'd0, e.perr});
`endif
  endtask

  // Monitor: pops and compares whenever a DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (vld1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat1 unexpected valid: instr %h", instr1);
      end else begin
        e = q1.pop_front();
        cmp("lat1", 1, instr1, flt1, perr1, e);
        last1 = e.instr; h1 = 1;
      end
    end else begin
      chk("lat1 idle fault", {31'd0, flt1}, 32'd0);
      if (h1) chk("lat1 hold", instr1, last1);
    end
    if (vld3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat3 unexpected valid: instr %h", instr3);
      end else begin
        e = q3.pop_front();
        cmp("lat3", 3, instr3, flt3, perr3, e);
        last3 = e.instr; h3 = 1;
      end
    end else begin
      chk("lat3 idle fault", {31'd0, flt3}, 32'd0);
      if (h3) chk("lat3 hold", instr3, last3);
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] ei,
                       input logic ef, input logic ep);
    exp_t e;
    bit ok;
    ok = 0;
    @(negedge clk);
    ld_valid = 0; ld_start = 0;
    fetch_req = 1; fetch_addr = addr;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (rdy1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL fetch accept timeout: addr %h ready 0 expected 1", addr);
      fetch_req = 0;
      return;
    end
    e.instr = ei; e.flt = ef; e.perr = ep; e.acc = cyc;
    q1.push_back(e);
    if (rdy3) q3.push_back(e);
    @(posedge clk);
  endtask

  task automatic ld_beat(input logic [31:0] d, input logic st, input logic [31:0] base,
                         input logic inj);
    @(negedge clk);
    fetch_req = 0;
    ld_valid = 1; ld_data = d; ld_start = st; ld_base = base;
`ifdef IMEM_PARITY_EN
    perr_inject = inj;
`else
    if (inj) $display("note: parity injection not built in");
`endif
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    fetch_req = 0; ld_valid = 0; ld_start = 0;
`ifdef IMEM_PARITY_EN
    perr_inject = 0;
`endif
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (q1.size() != 0 || q3.size() != 0); n++) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d expected 0/0", q1.size(), q3.size());
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " init cycles"}, n, 16);
    chk({tag, " busy3 after init"}, {31'd0, busy3}, 32'd0);
    chk({tag, " ld_ready after init"}, {30'd0, ldr1, ldr3}, 32'd3);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1;
    fetch_req = 0; fetch_addr = 0; ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0;
`ifdef IMEM_PARITY_EN
    perr_inject = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset busy", {30'd0, busy1, busy3}, 32'd3);
    chk("reset ready", {30'd0, rdy1, rdy3}, 32'd0);
    chk("reset ld_ready", {30'd0, ldr1, ldr3}, 32'd0);
    chk("reset valid", {30'd0, vld1, vld3}, 32'd0);
    chk("reset instr1", instr1, 32'd0);
    chk("reset instr3", instr3, 32'd0);
    @(negedge clk);
    reset = 0;
    wait_init("first");

    for (int i = 0; i < 16; i++) fetch(32'(i * 4), NOP, 0, 0);
    idle(); drain();

    ld_beat(32'hA, 1, 32'h8, 0);
    ld_beat(32'hB, 0, 32'h0, 0);
    ld_beat(32'hC, 0, 32'h0, 0);
    ld_beat(32'hD, 0, 32'h0, 0);
    idle();
    fetch(32'h8, 32'hA, 0, 0);
    fetch(32'hC, 32'hB, 0, 0);
    fetch(32'h10, 32'hC, 0, 0);
    fetch(32'h14, 32'hD, 0, 0);
    fetch(32'h18, NOP, 0, 0);
    idle(); drain();

    ld_beat(32'h11, 1, 32'h3C, 0);
    ld_beat(32'h22, 0, 32'h0, 0);
    idle();
    fetch(32'h3C, 32'h11, 0, 0);
    fetch(32'h0, 32'h22, 0, 0);
    fetch(32'h4, NOP, 0, 0);
    fetch(32'h2, NOP, 1, 0);
    fetch(32'h40, NOP, 1, 0);
    fetch(32'h8000_0008, NOP, 1, 0);
    fetch(32'h8, 32'hA, 0, 0);
    idle(); drain();

    // Fetch held against loader beats; last beat must be visible to the next-cycle fetch.
    @(negedge clk);
    fetch_req = 1; fetch_addr = 32'h28;
    ld_valid = 1; ld_start = 1; ld_base = 32'h20; ld_data = 32'h55;
    #1 chk("ready blocked beat0", {31'd0, rdy1}, 32'd0);
    @(posedge clk); @(negedge clk);
    ld_start = 0; ld_data = 32'h56;
    #1 chk("ready blocked beat1", {31'd0, rdy1}, 32'd0);
    @(posedge clk); @(negedge clk);
    ld_data = 32'h57;
    #1 chk("ready blocked beat2", {30'd0, rdy1, rdy3}, 32'd0);
    @(posedge clk); @(negedge clk);
    ld_valid = 0;
    #1 chk("ready after loader", {30'd0, rdy1, rdy3}, 32'd3);
    begin
      exp_t e;
      e.instr = 32'h57; e.flt = 0; e.perr = 0; e.acc = cyc;
      q1.push_back(e); q3.push_back(e);
    end
    @(posedge clk);
    fetch(32'h20, 32'h55, 0, 0);
    fetch(32'h24, 32'h56, 0, 0);
    idle(); drain();

    // Reset with two fetches in flight: responses are discarded.
    fetch(32'h20, 32'h55, 0, 0);
    fetch(32'h24, 32'h56, 0, 0);
    #2;
    reset = 1; fetch_req = 0;
    #1 chk("async busy rise", {30'd0, busy1, busy3}, 32'd3);
    q1.delete(); q3.delete(); h1 = 0; h3 = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    wait_init("second");
    fetch(32'h20, NOP, 0, 0);
    ld_beat(32'h77, 0, 32'h0, 0);
    idle();
    fetch(32'h0, 32'h77, 0, 0);
    idle(); drain();

`ifdef IMEM_PARITY_EN
    ld_beat(32'h99, 1, 32'h30, 1);
    ld_beat(32'h98, 0, 32'h0, 0);
    idle();
    fetch(32'h30, 32'h99, 0, 1);
    fetch(32'h34, 32'h98, 0, 0);
    idle(); drain();
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised single-port instruction memory for the RISC-V core.
- Serves the fetch stage through a pipelined request/valid port with configurable read latency.
- Accepts program images through a streaming valid/ready loader port.
- After reset it self-initialises every word to a NOP using a hardware state machine.
- Flags misaligned and out-of-range fetches.

Parameters:
- XLEN, 32, data and address width in bits.
- DEPTH, 1024, number of words; must be a power of two, minimum 4.
- RD_LAT, 1, fetch read latency in cycles; legal values 1 to 3.
- NOP_WORD, 32'h00000013, fill value after reset and instruction returned on a fault.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- init_busy  out  1  high while the post-reset fill is in progress.
- fetch_req  in  1  fetch request.
- fetch_addr  in  XLEN  byte address.
- fetch_ready  out  1  a request is accepted when fetch_req && fetch_ready.
- fetch_valid  out  1  response strobe.
- fetch_instr  out  XLEN  fetched word.
- fetch_fault  out  1  qualified by fetch_valid: request was misaligned or out of range.
- ld_start  in  1  load loader pointer from ld_base.
- ld_base  in  XLEN  byte address; word index = ld_base[AW+1:2].
- ld_valid  in  1  loader word valid.
- ld_data  in  XLEN  loader word.
- ld_ready  out  1  a word is accepted when ld_valid && ld_ready.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Address width: AW = log2(DEPTH). The word index is fetch_addr[AW+1:2].
- Reset values: state=INIT, init index=0, loader pointer=0, all pipeline valid bits=0, fetch_valid=0, fetch_fault=0, fetch_instr=0, fetch_ready=0, ld_ready=0, init_busy=1.
- State INIT:
  - Writes NOP_WORD to mem[idx] each cycle; idx increments.
  - After writing idx=DEPTH-1, moves to RUN on the next edge, so INIT lasts exactly DEPTH cycles.
  - fetch_ready=0 and ld_ready=0 throughout. ld_start is ignored.
- State RUN:
  - init_busy=0 and ld_ready=1.
  - fetch_ready = !ld_valid, because the memory is single-port and the loader has priority.
- ld_start:
  - Sets ptr = ld_base[AW+1:2].
  - If ld_start and a loader beat occur in the same cycle, the beat writes to the new base and ptr becomes base+1.
- Loader beat (RUN, ld_valid):
  - Writes mem[ptr] <= ld_data, then ptr <= ptr+1.
  - ptr wraps from DEPTH-1 to 0.
- Fetch accept:
  - An accepted request enters a RD_LAT-deep shift pipeline.
  - fetch_valid asserts exactly RD_LAT cycles after the accept edge.
  - Throughput is one request per cycle, with no bubbles from the memory itself.
  - There is no backpressure on responses; the consumer must always accept.
- Fault:
  - Raised when fetch_addr[1:0] != 0, or when fetch_addr >= 4*DEPTH (any upper bit set).
  - The response still appears after RD_LAT cycles with fetch_fault=1 and fetch_instr=NOP_WORD.
  - Memory is not read for a faulting request.
- Ordering:
  - A loader write in cycle N is visible to a fetch accepted in cycle N+1 or later.
  - A fetch accepted in cycle N is unaffected by loader writes from cycle N onward, because the data is captured at accept.
- Output hold: fetch_instr holds its last value while fetch_valid=0; fetch_fault is 0 whenever fetch_valid=0.
- Reset mid-operation:
  - In-flight fetches are discarded and no fetch_valid is produced.
  - The loader pointer is cleared.
  - INIT restarts from 0 and overwrites any loaded image.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on INIT and loader writes.
  - On read, the parity is rechecked. A mismatch adds a one-cycle-aligned output fetch_perr (1 bit, qualified by fetch_valid), and fetch_instr returns the raw data.
  - An additional input perr_inject (1 bit) inverts the stored parity bit on a loader write, for test use.
- Not defined: no parity storage, and the ports fetch_perr and perr_inject do not exist.

Decomposition:
- Package imem_pkg holds:
  - the NOP encoding constant;
  - the typedef for state (INIT, RUN);
  - the localparam function for the AW computation.
- Sub-module imem_rd_pipe: a RD_LAT-deep valid/data/fault shift register, instantiated once.
- Memory array, INIT/loader FSM, and accept logic stay in the top-level module.

Test Plan:
- Reset, DEPTH=16, RD_LAT=1 -> init_busy=1 for exactly 16 cycles. Then fetches of byte addresses 0x0 to 0x3C all return 0x00000013 with fault=0.
- ld_start with ld_base=0x8, then 3 beats 0xA, 0xB, 0xC -> fetches of 0x8, 0xC, 0x10 return 0xA, 0xB, 0xC; ptr ends at 5.
- With ld_base=0x3C (DEPTH=16), 2 beats 0x11, 0x22 -> mem[15]=0x11 and mem[0]=0x22 (wrap-around).
- RD_LAT=3, back-to-back requests on 4 consecutive cycles -> 4 consecutive fetch_valid pulses, starting 3 cycles after the first accept, in order.
- Fetch 0x2 and fetch 0x40 (DEPTH=16) -> fetch_fault=1 and fetch_instr=0x00000013. ld_valid held with fetch_req -> fetch_ready=0 until ld_valid drops.
- Reset asserted while 2 fetches are in flight -> no fetch_valid, and init_busy rises asynchronously. With IMEM_PARITY_EN defined: perr_inject on a write -> fetch_perr=1 on a fetch of that word.
